// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-port sequencer for the multicycle MIPS datapath.
//               Takes MemRead/MemWrite/IorD/IRWrite strobes from the control
//               unit, drives a req/ready memory port with a latched address,
//               and captures read data into the IR (fetch) or MDR (load).
//               Reports busy/done/err so the control FSM can stall.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               MemRead, MemWrite        access strobes (exactly one is legal)
//               IorD                     address select: 0 = pc, 1 = alu_out
//               IRWrite                  read destination: 1 = instr, 0 = mdr
//               pc, alu_out, wdata       address sources and store data
//               mem_req, mem_we          memory request / write enable
//               mem_addr, mem_wdata      latched address / store data
//               mem_rdata, mem_ready     read data and completion pulse
//               instr, mdr               instruction / memory data registers
//               busy                     stall request (combinational)
//               done, err                one-cycle completion / error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // A 1-bit counter is kept when the timeout is disabled so the logic
    // stays well-formed; it is never consulted in that case.
    localparam int                 c_cnt_w    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = (TIMEOUT > 0) ? c_cnt_w'(TIMEOUT - 1) : '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_mem_req;
    logic                r_we;
    logic                r_dest;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_instr;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_done;
    logic                r_err;
    logic [c_cnt_w-1:0]  r_cnt;

    logic [ADDR_W-1:0]   w_addr;
    logic                w_in_req;
    logic                w_one_strobe;
    logic                w_illegal;
    logic                w_timeout;

    assign w_addr       = IorD ? alu_out : pc;
    assign w_in_req     = (r_state == S_REQ);
    assign w_one_strobe = MemRead ^ MemWrite;
    // Misalignment only matters when an access is actually being requested.
    assign w_illegal    = (MemRead & MemWrite) | (w_one_strobe & (w_addr[1:0] != 2'b00));
    // Counter holds the number of REQ cycles already spent without ready,
    // so the last permitted cycle is the one where it equals TIMEOUT-1.
    assign w_timeout    = (TIMEOUT > 0) && (r_cnt == c_cnt_last);

    // Stall is raised in the same cycle as the strobe so the control FSM
    // never advances past an access that has not been accepted yet.
    assign busy      = w_in_req | (~w_in_req & (MemRead | MemWrite));

    assign mem_req   = r_mem_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign instr     = r_instr;
    assign mdr       = r_mdr;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_we      <= 1'b0;
            r_dest    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_instr   <= '0;
            r_mdr     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_REQ: begin
                    // Ready in the final permitted cycle takes priority
                    // over the timeout abort.
                    if (mem_ready) begin
                        if (!r_we) begin
                            if (r_dest) begin
                                r_instr <= mem_rdata;
                            end else begin
                                r_mdr <= mem_rdata;
                            end
                        end
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    // IDLE and DONE share the accept logic; DONE falls back
                    // to IDLE unless a new legal access is presented.
                    r_state <= S_IDLE;
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end else if (w_one_strobe) begin
                        r_addr    <= w_addr;
                        r_we      <= MemWrite;
                        r_wdata   <= wdata;
                        r_dest    <= IRWrite;
                        r_cnt     <= '0;
                        r_mem_req <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Each scenario task
//               drives stimulus, pushes the expected completion record into a
//               scoreboard queue, and pops/compares it when the DUT reports
//               done or err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              MemRead;
    logic              MemWrite;
    logic              IorD;
    logic              IRWrite;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] alu_out;
    logic [DATA_W-1:0] wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] mdr;
    logic              busy;
    logic              done;
    logic              err;

    mem_access_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .instr     (instr),
        .mdr       (mdr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] instr;
        logic [31:0] mdr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_instr;
    logic [31:0] m_mdr;
    int          n_checks;
    int          n_fail;

    // Inputs change 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
    endtask

    task automatic push_exp(input bit is_err);
        exp_t e;
        e.is_err = is_err;
        e.instr  = m_instr;
        e.mdr    = m_mdr;
        sb_q.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_strobes();
        mem_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, busy, done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req=%0b we=%0b busy=%0b done=%0b err=%0b, required all 0",
                     mem_req, mem_we, busy, done, err);
        end
        n_checks++;
        if ({mem_addr, mem_wdata, instr, mdr} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h instr=%h mdr=%h, required all 0",
                     mem_addr, mem_wdata, instr, mdr);
        end
        rst = 1'b0;
        m_instr = '0;
        m_mdr   = '0;
        tick();
    endtask

    task automatic test_fetch;
        exp_t e;
        MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h40;
        m_instr = 32'h8C220004;
        push_exp(1'b0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL fetch_busy_c0: got %0b, required 1", busy);
        end
        tick();                                     // cycle 1
        clear_strobes(); pc = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
            n_fail++;
            $display("FAIL fetch_req: got req=%0b we=%0b addr=%h, required req=1 we=0 addr=00000040",
                     mem_req, mem_we, mem_addr);
        end
        tick();                                     // cycle 2
        tick();                                     // cycle 3
        mem_ready = 1'b1; mem_rdata = 32'h8C220004;
        @(negedge clk);
        n_checks++;
        if ({mem_req, done} !== 2'b10) begin
            n_fail++; $display("FAIL fetch_c3: got req=%0b done=%0b, required req=1 done=0", mem_req, done);
        end
        tick();                                     // cycle 4
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL fetch_result: got empty scoreboard, required one entry");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if ({mem_req, done, err, instr, mdr} !== {1'b0, ~e.is_err, e.is_err, e.instr, e.mdr}) begin
                n_fail++;
                $display("FAIL fetch_result: got req=%0b done=%0b err=%0b instr=%h mdr=%h, required req=0 done=%0b err=%0b instr=%h mdr=%h",
                         mem_req, done, err, instr, mdr, ~e.is_err, e.is_err, e.instr, e.mdr);
            end
        end
        tick();                                     // cycle 5
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL fetch_done_pulse: got done=%0b, required 0", done);
        end
    endtask

    task automatic test_store;
        exp_t e;
        MemWrite = 1'b1; IorD = 1'b1; alu_out = 32'h100; wdata = 32'hDEADBEEF;
        push_exp(1'b0);
        tick();                                     // cycle 1
        clear_strobes(); alu_out = 32'h0; wdata = 32'h0;
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL store_req: got req=%0b we=%0b addr=%h wdata=%h, required req=1 we=1 addr=00000100 wdata=deadbeef",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick();                                     // cycle 2
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL store_result: got empty scoreboard, required one entry");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if ({mem_req, done, err, instr, mdr} !== {1'b0, ~e.is_err, e.is_err, e.instr, e.mdr}) begin
                n_fail++;
                $display("FAIL store_result: got req=%0b done=%0b err=%0b instr=%h mdr=%h, required req=0 done=%0b err=%0b instr=%h mdr=%h",
                         mem_req, done, err, instr, mdr, ~e.is_err, e.is_err, e.instr, e.mdr);
            end
        end
        tick();
    endtask

    task automatic test_load_mdr;
        exp_t e;
        MemRead = 1'b1; IorD = 1'b1; IRWrite = 1'b0; alu_out = 32'h200;
        m_mdr = 32'h12345678;
        push_exp(1'b0);
        tick();                                     // cycle 1
        clear_strobes();
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h200}) begin
            n_fail++;
            $display("FAIL load_req: got req=%0b we=%0b addr=%h, required req=1 we=0 addr=00000200",
                     mem_req, mem_we, mem_addr);
        end
        tick();                                     // cycle 2
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        tick();                                     // cycle 3
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL load_result: got empty scoreboard, required one entry");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if ({done, err, instr, mdr} !== {~e.is_err, e.is_err, e.instr, e.mdr}) begin
                n_fail++;
                $display("FAIL load_result: got done=%0b err=%0b instr=%h mdr=%h, required done=%0b err=%0b instr=%h mdr=%h",
                         done, err, instr, mdr, ~e.is_err, e.is_err, e.instr, e.mdr);
            end
        end
        tick();
    endtask

    // Covers both illegal cases: a misaligned single strobe and both strobes.
    task automatic test_illegal(input bit both, input logic [31:0] addr);
        exp_t e;
        MemRead = 1'b1; MemWrite = both; IorD = 1'b1; IRWrite = 1'b0; alu_out = addr;
        push_exp(1'b1);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL illegal_busy both=%0b: got %0b, required 1", both, busy);
        end
        tick();                                     // cycle 1
        clear_strobes();
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL illegal_result: got empty scoreboard, required one entry");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if ({mem_req, done, err, instr, mdr} !== {1'b0, ~e.is_err, e.is_err, e.instr, e.mdr}) begin
                n_fail++;
                $display("FAIL illegal_result both=%0b: got req=%0b done=%0b err=%0b instr=%h mdr=%h, required req=0 done=%0b err=%0b instr=%h mdr=%h",
                         both, mem_req, done, err, instr, mdr, ~e.is_err, e.is_err, e.instr, e.mdr);
            end
        end
        tick();                                     // cycle 2
        @(negedge clk);
        n_checks++;
        if ({err, mem_req} !== 2'b00) begin
            n_fail++; $display("FAIL illegal_pulse both=%0b: got err=%0b req=%0b, required 0 0", both, err, mem_req);
        end
    endtask

    task automatic test_ready_outside;
        mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        n_checks++;
        if ({done, err, mem_req, instr, mdr} !== {3'b000, m_instr, m_mdr}) begin
            n_fail++;
            $display("FAIL ready_outside: got done=%0b err=%0b req=%0b instr=%h mdr=%h, required 0 0 0 instr=%h mdr=%h",
                     done, err, mem_req, instr, mdr, m_instr, m_mdr);
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        int   req_cycles;
        req_cycles = 0;
        MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h80;
        push_exp(1'b1);
        tick();
        clear_strobes();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mem_req) break;
            req_cycles++;
            tick();
        end
        n_checks++;
        if (req_cycles != TIMEOUT) begin
            n_fail++; $display("FAIL timeout_len: got %0d req cycles, required %0d", req_cycles, TIMEOUT);
        end
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL timeout_result: got empty scoreboard, required one entry");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if ({done, err, instr, mdr} !== {~e.is_err, e.is_err, e.instr, e.mdr}) begin
                n_fail++;
                $display("FAIL timeout_result: got done=%0b err=%0b instr=%h mdr=%h, required done=%0b err=%0b instr=%h mdr=%h",
                         done, err, instr, mdr, ~e.is_err, e.is_err, e.instr, e.mdr);
            end
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({err, mem_req, busy} !== 3'b000) begin
            n_fail++; $display("FAIL timeout_idle: got err=%0b req=%0b busy=%0b, required 0 0 0", err, mem_req, busy);
        end
    endtask

    task automatic test_timeout_boundary;
        exp_t e;
        MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h84;
        m_instr = 32'hCAFEF00D;
        push_exp(1'b0);
        tick();                                     // REQ cycle 1
        clear_strobes();
        for (int i = 1; i < TIMEOUT; i++) tick();   // REQ cycle 15
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL tmo_edge_result: got empty scoreboard, required one entry");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if ({done, err, instr, mdr} !== {~e.is_err, e.is_err, e.instr, e.mdr}) begin
                n_fail++;
                $display("FAIL tmo_edge_result: got done=%0b err=%0b instr=%h mdr=%h, required done=%0b err=%0b instr=%h mdr=%h",
                         done, err, instr, mdr, ~e.is_err, e.is_err, e.instr, e.mdr);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        exp_t       e;
        logic [3:0] busy_seen;
        MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h10;
        m_instr = 32'hAAAA5555;
        push_exp(1'b0);
        @(negedge clk); busy_seen[0] = busy;
        tick();                                     // cycle 1: REQ
        clear_strobes();
        mem_ready = 1'b1; mem_rdata = 32'hAAAA5555;
        @(negedge clk); busy_seen[1] = busy;
        tick();                                     // cycle 2: DONE, new strobe
        mem_ready = 1'b0; mem_rdata = '0;
        MemRead = 1'b1; IorD = 1'b1; IRWrite = 1'b0; alu_out = 32'h204;
        @(negedge clk); busy_seen[2] = busy;
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL b2b_first: got empty scoreboard, required one entry");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if ({done, err, instr, mdr} !== {~e.is_err, e.is_err, e.instr, e.mdr}) begin
                n_fail++;
                $display("FAIL b2b_first: got done=%0b err=%0b instr=%h mdr=%h, required done=%0b err=%0b instr=%h mdr=%h",
                         done, err, instr, mdr, ~e.is_err, e.is_err, e.instr, e.mdr);
            end
        end
        m_mdr = 32'h5555AAAA;
        push_exp(1'b0);
        tick();                                     // cycle 3: second REQ
        clear_strobes();
        mem_ready = 1'b1; mem_rdata = 32'h5555AAAA;
        @(negedge clk); busy_seen[3] = busy;
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h204}) begin
            n_fail++; $display("FAIL b2b_req: got req=%0b addr=%h, required req=1 addr=00000204", mem_req, mem_addr);
        end
        n_checks++;
        if (busy_seen !== 4'b1111) begin
            n_fail++; $display("FAIL b2b_busy: got %b, required 1111", busy_seen);
        end
        tick();                                     // cycle 4: DONE
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL b2b_second: got empty scoreboard, required one entry");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if ({done, err, instr, mdr} !== {~e.is_err, e.is_err, e.instr, e.mdr}) begin
                n_fail++;
                $display("FAIL b2b_second: got done=%0b err=%0b instr=%h mdr=%h, required done=%0b err=%0b instr=%h mdr=%h",
                         done, err, instr, mdr, ~e.is_err, e.is_err, e.instr, e.mdr);
            end
        end
        tick();
    endtask

    task automatic test_reset_in_req;
        MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h88;
        tick();                                     // REQ cycle 1
        clear_strobes();
        tick();                                     // REQ cycle 2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_instr = '0;
        m_mdr   = '0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, busy, done, err, instr, mdr} !== {4'b0000, m_instr, m_mdr}) begin
            n_fail++;
            $display("FAIL reset_in_req: got req=%0b busy=%0b done=%0b err=%0b instr=%h mdr=%h, required all 0",
                     mem_req, busy, done, err, instr, mdr);
        end
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        pc        = '0;
        alu_out   = '0;
        wdata     = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        m_instr   = '0;
        m_mdr     = '0;

        test_reset();
        test_fetch();
        test_store();
        test_load_mdr();
        test_illegal(1'b0, 32'h102);
        test_illegal(1'b1, 32'h40);
        test_ready_outside();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_reset_in_req();

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
